// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared state encoding and time-of-day limits for alarm_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;

endpackage
`default_nettype wire

// File: rtl/time_add_min.sv
`default_nettype none
// ============================================================================
// Module      : time_add_min
// Description : Combinational hr:min + ADD_MIN minutes, wrapping at 60 min / 24 h.
// Revision    : 1.0 - initial release
// ============================================================================
module time_add_min
    import alarm_pkg::*;
#(
    parameter int unsigned ADD_MIN = 5
) (
    input  logic [4:0] i_hr,
    input  logic [5:0] i_min,
    output logic [4:0] o_hr,
    output logic [5:0] o_min
);

    logic [6:0] w_m;

    assign w_m = {1'b0, i_min} + 7'(ADD_MIN);

    always_comb begin
        o_hr  = i_hr;
        o_min = w_m[5:0];
        if (w_m > {1'b0, MIN_MAX}) begin
            o_min = 6'(w_m - 7'd60);
            o_hr  = (i_hr == HR_MAX) ? 5'd0 : i_hr + 5'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_ctrl
// Description : Alarm state machine (idle/armed/ringing/snooze) on the digital_clock time.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       set_en,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic       arm,
    input  logic       disarm,
    input  logic       snooze,
    input  logic       stop,
    output logic       ring,
    output logic       armed,
    output logic       snoozing,
    output logic [4:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic [2:0] snooze_left,
    output logic       set_err
);

    localparam logic [7:0] c_ring_last = 8'(RING_SECS - 1);
    localparam logic [2:0] c_snz_max   = 3'(MAX_SNOOZE);

    alarm_state_t r_state;
    logic         r_ring;
    logic         r_snoozing;
    logic         r_set_err;
    logic [4:0]   r_alarm_hr;
    logic [5:0]   r_alarm_min;
    logic [2:0]   r_snooze_left;
    logic [7:0]   r_ring_cnt;
    logic [4:0]   r_snz_hr;
    logic [5:0]   r_snz_min;
    logic [5:0]   r_sec_q;

    logic         w_tick;
    logic         w_alarm_match;
    logic         w_snz_match;
    logic         w_set_ok;
    logic [4:0]   w_tgt_hr;
    logic [5:0]   w_tgt_min;

    // Matches only fire on entry into second 0, so a static time never retriggers.
    assign w_tick        = (sec != r_sec_q);
    assign w_alarm_match = w_tick && (sec == 6'd0) && (hr == r_alarm_hr) && (min == r_alarm_min);
    assign w_snz_match   = w_tick && (sec == 6'd0) && (hr == r_snz_hr) && (min == r_snz_min);
    assign w_set_ok      = (set_hr <= HR_MAX) && (set_min <= MIN_MAX);

    time_add_min #(
        .ADD_MIN (SNOOZE_MIN)
    ) u_snz_add (
        .i_hr    (hr),
        .i_min   (min),
        .o_hr    (w_tgt_hr),
        .o_min   (w_tgt_min)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_q     <= 6'd0;
            r_alarm_hr  <= 5'd0;
            r_alarm_min <= 6'd0;
            r_set_err   <= 1'b0;
        end else begin
            r_sec_q   <= sec;
            r_set_err <= set_en && !w_set_ok;
            if (set_en && w_set_ok) begin
                r_alarm_hr  <= set_hr;
                r_alarm_min <= set_min;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ring        <= 1'b0;
            r_snoozing    <= 1'b0;
            r_snooze_left <= c_snz_max;
            r_ring_cnt    <= 8'd0;
            r_snz_hr      <= 5'd0;
            r_snz_min     <= 6'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) r_state <= ARMED;
                end
                ARMED: begin
                    if (disarm) begin
                        r_state <= IDLE;
                    end else if (w_alarm_match) begin
                        r_state       <= RINGING;
                        r_ring        <= 1'b1;
                        r_ring_cnt    <= 8'd0;
                        r_snooze_left <= c_snz_max;
                    end
                end
                RINGING: begin
                    if (disarm) begin
                        r_state <= IDLE;
                        r_ring  <= 1'b0;
                    end else if (stop) begin
                        r_state <= ARMED;
                        r_ring  <= 1'b0;
                    end else if (snooze && (r_snooze_left != 3'd0)) begin
                        r_state       <= SNOOZE;
                        r_ring        <= 1'b0;
                        r_snoozing    <= 1'b1;
                        r_snooze_left <= r_snooze_left - 3'd1;
                        r_snz_hr      <= w_tgt_hr;
                        r_snz_min     <= w_tgt_min;
                    end else if (w_tick) begin
                        if (r_ring_cnt == c_ring_last) begin
                            r_state <= ARMED;
                            r_ring  <= 1'b0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (disarm) begin
                        r_state    <= IDLE;
                        r_snoozing <= 1'b0;
                    end else if (stop) begin
                        r_state    <= ARMED;
                        r_snoozing <= 1'b0;
                    end else if (w_snz_match) begin
                        r_state    <= RINGING;
                        r_ring     <= 1'b1;
                        r_snoozing <= 1'b0;
                        r_ring_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ring     <= 1'b0;
                    r_snoozing <= 1'b0;
                end
            endcase
        end
    end

    assign ring        = r_ring;
    assign armed       = (r_state != IDLE);
    assign snoozing    = r_snoozing;
    assign alarm_hr    = r_alarm_hr;
    assign alarm_min   = r_alarm_min;
    assign snooze_left = r_snooze_left;
    assign set_err     = r_set_err;

endmodule
`default_nettype wire
